div_share_sched: RTL and testbench

- Round-robin scheduler that shares one divider_10by5 instance between two requesters.
- Each requester presents a parallel 10-bit dividend and 5-bit divisor.
- The block arbitrates, resets the divider, and drives its start pulse and 5-bit serial load sequence.
- It waits for done with a watchdog, then captures quotient/remainder/flags and returns them on a shared response bus tagged with the requester id.

---
 rtl/div_pkg.sv | 47 ++++
 rtl/rr_arb2.sv | 32 +++
 rtl/div_share_sched.sv | 166 ++++++++++++++++
 tb/tb_div_share_sched.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the divider-sharing scheduler: FSM encoding,
// serial load word order and watchdog default.
package div_pkg;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_CLR    = 4'd1;
    localparam logic [3:0] ST_START  = 4'd2;
    localparam logic [3:0] ST_GAP    = 4'd3;
    localparam logic [3:0] ST_LD_HI  = 4'd4;
    localparam logic [3:0] ST_LD_LO  = 4'd5;
    localparam logic [3:0] ST_LD_DVS = 4'd6;
    localparam logic [3:0] ST_WAIT   = 4'd7;
    localparam logic [3:0] ST_CAP_R  = 4'd8;
    localparam logic [3:0] ST_RESP   = 4'd9;

    typedef enum logic [3:0] {
        S_IDLE   = ST_IDLE,
        S_CLR    = ST_CLR,
        S_START  = ST_START,
        S_GAP    = ST_GAP,
        S_LD_HI  = ST_LD_HI,
        S_LD_LO  = ST_LD_LO,
        S_LD_DVS = ST_LD_DVS,
        S_WAIT   = ST_WAIT,
        S_CAP_R  = ST_CAP_R,
        S_RESP   = ST_RESP
    } state_t;

    // Order in which the divider expects its three serial words.
    localparam logic [1:0] W_HI  = 2'd0;
    localparam logic [1:0] W_LO  = 2'd1;
    localparam logic [1:0] W_DVS = 2'd2;

    localparam int TIMEOUT_DEF = 127;

    function automatic logic [4:0] load_word(input logic [1:0] sel,
                                             input logic [9:0] dvd,
                                             input logic [4:0] dvs);
        case (sel)
            W_HI:    return dvd[9:5];
            W_LO:    return dvd[4:0];
            W_DVS:   return dvs;
            default: return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered last-grant
// pointer. The requester not served last wins a tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    logic last;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            gnt[0] = req[0] && (last || !req[1]);
            gnt[1] = req[1] && (!last || !req[0]);
        end
    end

    assign gnt_id = gnt[1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            last <= 1'b0;
        end else if (|gnt) begin
            last <= gnt_id;
        end
    end

endmodule

// File: rtl/div_share_sched.sv
// Shares one serial-load divider between two requesters: arbitrate, reset and
// load the divider, wait for done under a watchdog, return a tagged response.
module div_share_sched
    import div_pkg::*;
#(
    parameter int LOAD_GAP = 1,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [9:0] dividend0,
    input  logic [9:0] dividend1,
    input  logic [4:0] divisor0,
    input  logic [4:0] divisor1,
    output logic       ack0,
    output logic       ack1,
    output logic       resp_valid,
    output logic       resp_id,
    output logic [4:0] quotient,
    output logic [4:0] remainder,
    output logic       ov,
    output logic       dbz,
    output logic       tmo,
    output logic       busy,
    output logic       div_rst,
    output logic       div_start,
    output logic [4:0] div_data,
    input  logic       div_ov,
    input  logic       div_dbz,
    input  logic       div_done,
    input  logic [4:0] div_out
);

    localparam logic [1:0] GAP_LAST = 2'(LOAD_GAP > 0 ? LOAD_GAP - 1 : 0);
    localparam logic [6:0] WD_LAST  = 7'(TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [1:0] gnt;
    logic       gnt_id;
    logic       arb_en;
    logic [1:0] gap_cnt;
    logic [6:0] wd;
    logic [9:0] dvd_r;
    logic [4:0] dvs_r;
    logic       id_r;
    logic [4:0] q_c;
    logic       ov_c;
    logic       dbz_c;
    logic       expire;

    // Grants are suppressed while reset is asserted so no ack escapes.
    assign arb_en = (state == S_IDLE) && rst;
    assign expire = (state == S_WAIT) && !div_done && (wd == WD_LAST);

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .en     (arb_en),
        .req    ({req1, req0}),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    always_comb begin
        state_nxt  = state;
        ack0       = 1'b0;
        ack1       = 1'b0;
        resp_valid = 1'b0;
        div_rst    = 1'b0;
        div_start  = 1'b0;
        div_data   = 5'd0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                ack0 = gnt[0];
                ack1 = gnt[1];
                if (|gnt) state_nxt = S_CLR;
            end
            S_CLR: begin
                div_rst   = 1'b1;
                state_nxt = S_START;
            end
            S_START: begin
                div_start = 1'b1;
                state_nxt = (LOAD_GAP > 0) ? S_GAP : S_LD_HI;
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) state_nxt = S_LD_HI;
            end
            S_LD_HI: begin
                div_data  = load_word(W_HI, dvd_r, dvs_r);
                state_nxt = S_LD_LO;
            end
            S_LD_LO: begin
                div_data  = load_word(W_LO, dvd_r, dvs_r);
                state_nxt = S_LD_DVS;
            end
            S_LD_DVS: begin
                div_data  = load_word(W_DVS, dvd_r, dvs_r);
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (div_done)    state_nxt = S_CAP_R;
                else if (expire) state_nxt = S_RESP;
            end
            S_CAP_R: state_nxt = S_RESP;
            S_RESP: begin
                resp_valid = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            gap_cnt   <= 2'd0;
            wd        <= 7'd0;
            resp_id   <= 1'b0;
            quotient  <= 5'd0;
            remainder <= 5'd0;
            ov        <= 1'b0;
            dbz       <= 1'b0;
            tmo       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_START)     gap_cnt <= 2'd0;
            else if (state == S_GAP)  gap_cnt <= gap_cnt + 2'd1;
            if (state == S_LD_DVS)    wd <= 7'd0;
            else if (state == S_WAIT) wd <= wd + 7'd1;
            // Response fields change only on the edge into RESP.
            if (expire) begin
                resp_id   <= id_r;
                quotient  <= 5'd0;
                remainder <= 5'd0;
                ov        <= 1'b0;
                dbz       <= 1'b0;
                tmo       <= 1'b1;
            end else if (state == S_CAP_R) begin
                resp_id   <= id_r;
                quotient  <= q_c;
                remainder <= div_out;
                ov        <= ov_c;
                dbz       <= dbz_c;
                tmo       <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (|gnt) begin
            dvd_r <= gnt[1] ? dividend1 : dividend0;
            dvs_r <= gnt[1] ? divisor1 : divisor0;
            id_r  <= gnt_id;
        end
        if (state == S_WAIT && div_done) begin
            q_c   <= div_out;
            ov_c  <= div_ov;
            dbz_c <= div_dbz;
        end
    end

endmodule

// File: tb/tb_div_share_sched.sv
// Directed bench for div_share_sched with a cycle-level divider model that
// decodes the serial load and answers after a chosen number of WAIT cycles.
module tb_div_share_sched;

    localparam int LOAD_GAP = 1;
    localparam int TIMEOUT  = 127;
    localparam int L_DVS    = 5 + LOAD_GAP;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [9:0] dividend0 = '0, dividend1 = '0;
    logic [4:0] divisor0 = '0, divisor1 = '0;
    logic       div_ov = 1'b0, div_dbz = 1'b0, div_done = 1'b0;
    logic [4:0] div_out = '0;
    logic       ack0, ack1, resp_valid, resp_id, ov, dbz, tmo, busy;
    logic       div_rst, div_start;
    logic [4:0] quotient, remainder, div_data;

    int n_cmp = 0;
    int n_err = 0;

    div_share_sched #(.LOAD_GAP(LOAD_GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .dividend0(dividend0), .dividend1(dividend1),
        .divisor0(divisor0), .divisor1(divisor1),
        .ack0(ack0), .ack1(ack1), .resp_valid(resp_valid), .resp_id(resp_id),
        .quotient(quotient), .remainder(remainder), .ov(ov), .dbz(dbz),
        .tmo(tmo), .busy(busy), .div_rst(div_rst), .div_start(div_start),
        .div_data(div_data), .div_ov(div_ov), .div_dbz(div_dbz),
        .div_done(div_done), .div_out(div_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference divider: 5-bit quotient, overflow when it would not fit.
    function automatic void ref_div(input logic [9:0] a, input logic [4:0] b,
                                    output logic [4:0] q, output logic [4:0] r,
                                    output logic o, output logic z);
        int qq;
        q = '0; r = '0; o = 1'b0; z = 1'b0;
        if (b == 5'd0) begin
            z = 1'b1;
        end else begin
            qq = int'(a) / int'(b);
            if (qq > 31) o = 1'b1;
            else begin
                q = 5'(qq);
                r = 5'(int'(a) % int'(b));
            end
        end
    endfunction

    task automatic wait_ack(output int id);
        id = -1;
        for (int k = 0; k < 40 && id < 0; k++) begin
            if (ack0 && ack1)  id = 2;
            else if (ack0)     id = 0;
            else if (ack1)     id = 1;
            if (id < 0) @(negedge clk);
        end
        if (id < 0) chk("ack_seen", 32'd0, 32'd1);
    endtask

    // Entered at the ack cycle; c counts cycles after the grant.
    task automatic serve(input bit keep, input int dly, input bit to,
                         input logic id_exp, input logic [9:0] dvd, input logic [4:0] dvs);
        logic [4:0] w0, w1, w2, mq, mr, eq, er;
        logic       mo, mz, eo, ez;
        int         stray, acks, lat, lat_exp;
        w0 = '0; w1 = '0; w2 = '0; mq = '0; mr = '0; mo = 1'b0; mz = 1'b0;
        stray = 0; acks = 0; lat = -1;
        ref_div(dvd, dvs, eq, er, eo, ez);
        if (to) begin eq = '0; er = '0; eo = 1'b0; ez = 1'b0; end
        lat_exp = to ? L_DVS + TIMEOUT + 1 : L_DVS + dly + 2;
        for (int c = 1; c <= L_DVS + TIMEOUT + 20 && lat < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("div_rst", 32'(div_rst), 32'd1);
                if (!keep) begin req0 = 1'b0; req1 = 1'b0; end
            end
            if (c == 2) chk("div_start", 32'(div_start), 32'd1);
            if (c == L_DVS - 2)      w0 = div_data;
            else if (c == L_DVS - 1) w1 = div_data;
            else if (c == L_DVS) begin
                w2 = div_data;
                ref_div({w0, w1}, w2, mq, mr, mo, mz);
            end else if (div_data != 5'd0) stray++;
            if (!keep && (ack0 || ack1)) acks++;
            if (!to) begin
                if (c == L_DVS + dly) begin
                    div_done = 1'b1; div_out = mq; div_ov = mo; div_dbz = mz;
                end else if (c == L_DVS + dly + 1) begin
                    div_done = 1'b0; div_out = mr; div_ov = 1'b0; div_dbz = 1'b0;
                end else begin
                    div_out = '0;
                end
            end
            if (resp_valid) lat = c;
        end
        if (lat < 0) begin
            chk("resp_seen", 32'd0, 32'd1);
        end else begin
            chk("latency", 32'(lat), 32'(lat_exp));
            chk("resp_id", 32'(resp_id), 32'(id_exp));
            chk("quotient", 32'(quotient), 32'(eq));
            chk("remainder", 32'(remainder), 32'(er));
            chk("ov", 32'(ov), 32'(eo));
            chk("dbz", 32'(dbz), 32'(ez));
            chk("tmo", 32'(tmo), 32'(to));
            chk("word_hi", 32'(w0), 32'(dvd[9:5]));
            chk("word_lo", 32'(w1), 32'(dvd[4:0]));
            chk("word_dvs", 32'(w2), 32'(dvs));
            chk("stray_data", 32'(stray), 32'd0);
            chk("extra_ack", 32'(acks), 32'd0);
        end
        @(negedge clk);
        chk("resp_pulse", 32'(resp_valid), 32'd0);
        chk("idle_after", 32'(busy), 32'd0);
    endtask

    task automatic job(input int id, input logic [9:0] dvd, input logic [4:0] dvs,
                       input int dly, input bit to);
        int g;
        @(negedge clk);
        if (id == 0) begin req0 = 1'b1; dividend0 = dvd; divisor0 = dvs; end
        else         begin req1 = 1'b1; dividend1 = dvd; divisor1 = dvs; end
        #1;
        wait_ack(g);
        chk("grant", 32'(g), 32'(id));
        serve(1'b0, dly, to, id[0], dvd, dvs);
    endtask

    initial begin
        int g;
        int exp_g;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", 32'({ack1, ack0}), 32'd0);
        chk("rst_resp", 32'(resp_valid), 32'd0);
        chk("rst_divctl", 32'({div_rst, div_start}), 32'd0);
        chk("rst_data", 32'(div_data), 32'd0);
        chk("rst_fields", 32'({quotient, remainder, ov, dbz, tmo, resp_id}), 32'd0);
        rst = 1'b1;

        job(0, 10'd963, 5'd5, 1, 1'b0);   // words 11110 00011 00101, overflows
        job(0, 10'd100, 5'd5, 2, 1'b0);   // q=20 r=0
        job(0, 10'd175, 5'd0, 1, 1'b0);   // divide by zero
        job(1, 10'd1000, 5'd3, 4, 1'b0);  // overflow on requester 1

        // Both requesters held; last served was 1, so order is 0,1,0,1.
        @(negedge clk);
        dividend0 = 10'd100; divisor0 = 5'd5;
        dividend1 = 10'd200; divisor1 = 5'd7;
        req0 = 1'b1; req1 = 1'b1;
        #1;
        for (int j = 0; j < 4; j++) begin
            exp_g = j % 2;
            wait_ack(g);
            chk("rr_grant", 32'(g), 32'(exp_g));
            if (g == 1) serve(1'b1, 2, 1'b0, 1'b1, 10'd200, 5'd7);
            else        serve(1'b1, 2, 1'b0, 1'b0, 10'd100, 5'd5);
        end
        req0 = 1'b0; req1 = 1'b0;

        job(1, 10'd200, 5'd7, 0, 1'b1);   // divider never answers
        job(0, 10'd100, 5'd5, 3, 1'b0);   // normal job clears tmo

        // Reset asserted while the low dividend word is on the bus.
        @(negedge clk);
        req0 = 1'b1; dividend0 = 10'd200; divisor0 = 5'd7;
        #1;
        wait_ack(g);
        chk("rst_job_grant", 32'(g), 32'd0);
        for (int c = 1; c <= 4 + LOAD_GAP; c++) begin
            @(negedge clk);
            if (c == 1) req0 = 1'b0;
        end
        chk("pre_rst_ld_lo", 32'(div_data), 32'(dividend0[4:0]));
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_start", 32'(div_start), 32'd0);
        chk("mid_rst_data", 32'(div_data), 32'd0);
        chk("mid_rst_ack", 32'({ack1, ack0}), 32'd0);
        chk("mid_rst_q", 32'(quotient), 32'd0);
        rst = 1'b1;
        job(0, 10'd200, 5'd7, 2, 1'b0);   // q=28 r=4 after fresh div_rst

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
